// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice: FSM state and
// transaction owner encodings, RISC-V load/store size codes, latency bounds
// and the alignment rule used when MEM_ARB_ALIGN_CHECK_EN is defined.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Read latency must fit the 3-bit countdown counter.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 7;
  localparam int CNT_W            = 3;

  // Fetches are always words; byte accesses never fault; halves need an even
  // address; words (and unknown size codes, handled as words) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic       is_fetch,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    if (is_fetch) begin
      mis = (addr_lo != 2'b00);
    end else begin
      case (funct3)
        F3_B, F3_BU: mis = 1'b0;
        F3_H, F3_HU: mis = addr_lo[0];
        default:     mis = (addr_lo != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's right-aligned data and the 32-bit
// memory word: store byte masks / replicated store data on the way out, and
// byte/half extraction with sign or zero extension on the way back.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lane_data,
  input  logic        ld_is_fetch,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: replicate the small datum into every lane and let the mask pick the lane.
  always_comb begin
    st_mask      = 4'b1111;
    st_lane_data = st_data;
    case (st_funct3)
      F3_B: begin
        st_mask      = 4'b0001 << st_addr_lo;
        st_lane_data = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_mask      = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_lane_data = {2{st_data[15:0]}};
      end
      default: begin
        st_mask      = 4'b1111;
        st_lane_data = st_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half; halves ignore addr[0] so an odd half uses its even neighbour.
  always_comb begin
    byte_sel = ld_word[7:0];
    case (ld_addr_lo)
      2'd0:    byte_sel = ld_word[7:0];
      2'd1:    byte_sel = ld_word[15:8];
      2'd2:    byte_sel = ld_word[23:16];
      default: byte_sel = ld_word[31:24];
    endcase
    half_sel = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    ld_data = ld_word;
    if (!ld_is_fetch) begin
      case (ld_funct3)
        F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
        F3_BU:   ld_data = {24'h000000, byte_sel};
        F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
        F3_HU:   ld_data = {16'h0000, half_sel};
        default: ld_data = ld_word;
      endcase
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one synchronous memory port between instruction fetch and
// load/store. One transaction in flight, data side wins ties, responses are a
// single-cycle valid pulse to the owning requester.
// Optional macro MEM_ARB_ALIGN_CHECK_EN: misaligned requests are answered
// with an error pulse instead of touching memory.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1  // legal 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

  arb_state_t       state, state_next;
  owner_t           owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      resp_data, resp_data_next;
  logic             resp_err, resp_err_next;
  logic [2:0]       ld_funct3, ld_funct3_next;
  logic [1:0]       ld_addr_lo, ld_addr_lo_next;

  logic        can_accept;
  logic        accept;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  st_mask;
  logic [31:0] st_lane_data;
  logic [31:0] ld_data;

  assign can_accept = (state == ST_IDLE) || (state == ST_RESP);
  assign d_ready    = can_accept & d_req;
  assign if_ready   = can_accept & if_req & ~d_req;
  assign accept     = d_ready | if_ready;
  assign is_store   = d_ready & d_we;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misaligned = d_ready  ? is_misaligned(1'b0, d_funct3, d_addr[1:0]) :
                      if_ready ? is_misaligned(1'b1, F3_W, if_addr[1:0])    : 1'b0;
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_lane (
    .st_funct3    (d_funct3),
    .st_addr_lo   (d_addr[1:0]),
    .st_data      (d_wdata),
    .st_mask      (st_mask),
    .st_lane_data (st_lane_data),
    .ld_is_fetch  (owner == OWN_IF),
    .ld_funct3    (ld_funct3),
    .ld_addr_lo   (ld_addr_lo),
    .ld_word      (mem_rdata),
    .ld_data      (ld_data)
  );

  // Memory strobes come straight from the winning request in its accept cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wmask = 4'b0000;
    mem_addr  = 30'd0;
    mem_wdata = 32'd0;
    if (d_ready) begin
      mem_addr = d_addr[31:2];
      if (!misaligned) begin
        mem_en = 1'b1;
        if (d_we) begin
          mem_we    = 1'b1;
          mem_wmask = st_mask;
          mem_wdata = st_lane_data;
        end
      end
    end else if (if_ready) begin
      mem_addr = if_addr[31:2];
      mem_en   = ~misaligned;
    end
  end

  // Next-state: accept in IDLE/RESP, count down the read latency in WAIT, capture formatted data.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    cnt_next        = cnt;
    resp_data_next  = resp_data;
    resp_err_next   = resp_err;
    ld_funct3_next  = ld_funct3;
    ld_addr_lo_next = ld_addr_lo;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          owner_next      = d_ready ? OWN_D : OWN_IF;
          ld_funct3_next  = d_ready ? d_funct3 : F3_W;
          ld_addr_lo_next = d_ready ? d_addr[1:0] : if_addr[1:0];
          resp_data_next  = 32'd0;
          resp_err_next   = misaligned;
          if (misaligned || is_store) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end
        end else begin
          state_next     = ST_IDLE;
          owner_next     = OWN_NONE;
          resp_data_next = 32'd0;
          resp_err_next  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next     = ST_RESP;
          resp_data_next = ld_data;
          resp_err_next  = 1'b0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

  // State and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      cnt        <= '0;
      resp_data  <= 32'd0;
      resp_err   <= 1'b0;
      ld_funct3  <= 3'b000;
      ld_addr_lo <= 2'b00;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      cnt        <= cnt_next;
      resp_data  <= resp_data_next;
      resp_err   <= resp_err_next;
      ld_funct3  <= ld_funct3_next;
      ld_addr_lo <= ld_addr_lo_next;
    end
  end

  assign if_valid = (state == ST_RESP) && (owner == OWN_IF);
  assign d_valid  = (state == ST_RESP) && (owner == OWN_D);
  assign if_rdata = if_valid ? resp_data : 32'd0;
  assign d_rdata  = d_valid  ? resp_data : 32'd0;
  assign if_err   = if_valid & resp_err;
  assign d_err    = d_valid  & resp_err;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single synchronous memory port between the instruction-fetch path and the load/store path of the multicycle core. Accepts one request at a time under a valid/ready handshake, drives the memory for the configured read latency, formats load data (byte/half, sign/zero extension) and store byte masks, and returns a one-cycle response pulse to the requester that owns the transaction. Sits between the control unit and the unified instruction/data memory.

## Interface
- `READ_LATENCY`, 1: cycles from `mem_en` until `mem_rdata` is valid; legal range 1..7.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until accepted.
- `if_addr`  in  32  fetch byte address.
- `if_ready`  out  1  fetch request accepted this cycle.
- `if_valid`  out  1  one-cycle fetch response pulse.
- `if_rdata`  out  32  fetched word; valid with `if_valid`.
- `d_req`  in  1  data request; held until accepted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_funct3`  in  3  RISC-V size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data, right-aligned.
- `d_ready`  out  1  data request accepted this cycle.
- `d_valid`  out  1  one-cycle data response pulse (load data or store ack).
- `d_rdata`  out  32  formatted load data; 0 for stores.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_wmask`  out  4  byte write enables.
- `mem_addr`  out  30  word address (byte address [31:2]).
- `mem_wdata`  out  32  lane-aligned store data.
- `mem_rdata`  in  32  memory read word.
- `if_err`, `d_err`  out  1  alignment fault with response (only under macro; otherwise tied 0).

## Operation
- FSM states: IDLE, WAIT, RESP. Reset: IDLE, owner = none, latency counter 0, all outputs 0.
- Acceptance only in IDLE or RESP. `d_req` has fixed priority over `if_req` when both high; losing requester sees ready=0 and keeps holding.
- Accept cycle T: ready to winner, `mem_en`=1, `mem_addr`/`mem_we`/`mem_wmask`/`mem_wdata` driven combinationally from winner inputs; owner registered.
- Store: memory writes at end of T; next state RESP; `d_valid`=1 at T+1, `d_rdata`=0.
- Load/fetch: next state WAIT, counter loaded with READ_LATENCY−1; counts down; at counter 0 captures `mem_rdata` into the response register (formatted by owner/funct3/addr[1:0]) and moves to RESP; valid at T+READ_LATENCY+1.
- RESP: owner valid=1 for exactly one cycle; new accept allowed same cycle; next state WAIT/RESP for a new accept, else IDLE.
- Store masks: sb `0001<<addr[1:0]`, data byte replicated ×4; sh `0011<<{addr[1],0}`, half replicated ×2; sw `1111`.
- Loads: lb/lbu select byte addr[1:0], sign/zero extend; lh/lhu select half addr[1]; lw whole word. Fetch always whole word. Undefined funct3 treated as lw.
- Reset asserted mid-transaction: immediate return to IDLE, pending response dropped, no valid pulse; a store already issued is not undone.

## Timing
- Load/fetch latency: accept→valid = READ_LATENCY+1 cycles. Store: 1 cycle.
- Back-to-back throughput: one transaction per READ_LATENCY+1 cycles (loads), per cycle (stores).
- ready is combinational from req and state; req must not depend combinationally on ready.
- Response data registered; stable only during the valid cycle.

## Configuration
- `MEM_ARB_ALIGN_CHECK_EN` defined: misaligned requests (fetch addr[1:0]≠0, h/hu at addr[0]=1, w at addr[1:0]≠0) are accepted with `mem_en`=0, go straight to RESP, respond at T+1 with rdata 0 and owner err=1.
- Undefined: no check; `*_err` tied 0; misaligned word accesses use the aligned-down word; halfwords use addr[1] only.

## Structure
- Package `mem_arb_pkg`: state enum, owner enum (NONE/IF/D), funct3 size constants, READ_LATENCY bounds.
- One sub-module, `mem_lane_align`: combinational store mask/data steering and load extraction/extension.

## Test plan
- Reset, then load lw @0x100, READ_LATENCY=2, mem word 0xDEADBEEF → `d_valid` at accept+3, `d_rdata`=0xDEADBEEF.
- Both reqs high same cycle → `d_ready`=1, `if_ready`=0; fetch accepted in the data RESP cycle.
- sb 0x000000A5 @0x203 → `mem_wmask`=1000, `mem_wdata`=0xA5A5A5A5, `d_valid` next cycle.
- lb @0x102 on word 0x0080FF00 → 0xFFFFFF80; lhu @0x102 → 0x00000080.
- Reset asserted during WAIT → next cycle IDLE, no valid pulse, new fetch accepted after release.
- With macro: lw @0x102 → `mem_en`=0, `d_valid`+`d_err` at T+1, rdata 0.
